hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It generates the 2-bit operand-select codes consumed by the 3:1 forwarding muxes in Execute, and the stall/flush controls for the Fetch, Decode and Execute pipeline registers. It keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB register-tracking fields, so it needs only Decode-stage fields and the branch decision from the datapath.

## Interface
Parameters:
- REG_AW, 5, register-index width
- CNT_W, 32, performance-counter width (used only with HAZARD_PERF_CNT_EN)

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Rs1D  in  REG_AW  Decode source register 1
- Rs2D  in  REG_AW  Decode source register 2
- RdD  in  REG_AW  Decode destination register
- RegWriteD  in  1  Decode instruction writes rd
- ResultSrcD  in  2  Decode result source; 2'b01 = load
- PCSrcE  in  1  branch/jump taken in Execute
- ForwardAE  out  2  select for Execute operand A mux
- ForwardBE  out  2  select for Execute operand B mux
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register
- StallCnt  out  CNT_W  load-use stall cycles counted
- FlushCnt  out  CNT_W  branch-flush events counted

## Operation
- Shadow stages E, M, W each hold {rs1, rs2, rd, regwrite, isload}. M and W use only rd and regwrite.
- Forward select encoding, applied to A with rs1E and to B with rs2E:
  - 2'b10 (ALU result from Memory) when regwriteM, rdM != 0 and rdM == rsE.
  - Otherwise 2'b01 (Writeback result) when regwriteW, rdW != 0 and rdW == rsE.
  - Otherwise 2'b00 (register file).
  - Memory always has priority over Writeback. x0 is never forwarded. 2'b11 is never driven.
- Load-use hazard: lwStall = isloadE & (rdE != 0) & ((Rs1D == rdE) | (Rs2D == rdE)).
- StallF = StallD = lwStall.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE.
- Shadow update at each clock edge:
  - E loads a bubble (all fields 0) when FlushE; otherwise E loads {Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD == 2'b01}.
  - M loads E; W loads M.
  - Stall and flush never freeze M or W.
- Simultaneous lwStall and PCSrcE: both asserted; the branch flush wins in effect because the stalled Decode instruction is discarded by FlushD.

## Timing
- Reset: all shadow fields are 0 asynchronously. While reset is high, every output is forced to 0, including StallCnt and FlushCnt.
- Reset deasserted mid-operation: the pipeline restarts empty, so no forwarding or stall can be generated until new instructions enter.
- All outputs except the counters are combinational from shadow state and current inputs, with zero-cycle latency. The datapath registers them at the same edge as its pipeline registers.
- A load in E with a dependent instruction in D asserts the stall for exactly one cycle. On the next cycle the load sits in M with isload cleared from E, and the dependent instruction gets ForwardxE = 2'b01 when the load reaches W.
- The counters increment at the clock edge in a cycle where the condition is true, so the new value is visible one cycle later. They wrap from all-ones to 0.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments on each cycle where lwStall is high.
  - FlushCnt increments on each cycle where PCSrcE is high.
- Undefined: the counter registers are not built, and StallCnt and FlushCnt are tied to 0.

## Test plan
- Reset asserted mid-stream with regwriteM = 1 and rdM = 5 → all outputs 0 immediately. After release, Rs1D = 5 flowing into E gives ForwardAE = 00.
- add x5 followed by a consumer of x5 (rs1E = 5, rdM = 5) → ForwardAE = 10. One cycle later, with rdW = 5 and no M match, a following consumer gets ForwardAE = 01.
- rdM = rdW = 7 with rs2E = 7 → ForwardBE = 10 (Memory priority). rd = 0 with rs = 0 → 00.
- Load x3 in E, Rs2D = 3 → StallF = StallD = FlushE = 1 for one cycle. Next cycle the stall is 0 and E holds a bubble. StallCnt goes 0 → 1 with HAZARD_PERF_CNT_EN.
- PCSrcE = 1 in the same cycle as a load-use condition → FlushD = FlushE = StallF = 1. FlushCnt increments by 1.
- HAZARD_PERF_CNT_EN with the counter preset near all-ones: 2 stall cycles → StallCnt wraps to 0. Build without the macro → both counters 0 throughout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: forwarding selects, load-use stall, branch flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  logic [REG_AW-1:0] r_rs1E, r_rs2E, r_rdE, r_rdM, r_rdW;
  logic              r_regWriteE, r_isLoadE, r_regWriteM, r_regWriteW;

  logic              w_lwStall;
  logic              w_flushE;
  logic [1:0]        w_fwdA, w_fwdB;

  // Memory stage outranks Writeback; x0 is never a forwarding source.
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs,
                                        input logic [REG_AW-1:0] rdM, input logic regWriteM,
                                        input logic [REG_AW-1:0] rdW, input logic regWriteW);
    if (regWriteM && (rdM != '0) && (rdM == rs))
      return 2'b10;
    else if (regWriteW && (rdW != '0) && (rdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    w_lwStall = r_isLoadE && (r_rdE != '0) && ((Rs1D == r_rdE) || (Rs2D == r_rdE));
    w_flushE  = w_lwStall || PCSrcE;
    w_fwdA    = fwdSel(r_rs1E, r_rdM, r_regWriteM, r_rdW, r_regWriteW);
    w_fwdB    = fwdSel(r_rs2E, r_rdM, r_regWriteM, r_rdW, r_regWriteW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs1E      <= '0;
      r_rs2E      <= '0;
      r_rdE       <= '0;
      r_regWriteE <= 1'b0;
      r_isLoadE   <= 1'b0;
      r_rdM       <= '0;
      r_regWriteM <= 1'b0;
      r_rdW       <= '0;
      r_regWriteW <= 1'b0;
    end else begin
      if (w_flushE) begin
        r_rs1E      <= '0;
        r_rs2E      <= '0;
        r_rdE       <= '0;
        r_regWriteE <= 1'b0;
        r_isLoadE   <= 1'b0;
      end else begin
        r_rs1E      <= Rs1D;
        r_rs2E      <= Rs2D;
        r_rdE       <= RdD;
        r_regWriteE <= RegWriteD;
        r_isLoadE   <= (ResultSrcD == 2'b01);
      end
      r_rdM       <= r_rdE;
      r_regWriteM <= r_regWriteE;
      r_rdW       <= r_rdM;
      r_regWriteW <= r_regWriteM;
    end
  end

  // Reset masks everything, including a PCSrcE the datapath may still be driving.
  assign ForwardAE = reset ? 2'b00 : w_fwdA;
  assign ForwardBE = reset ? 2'b00 : w_fwdB;
  assign StallF    = !reset && w_lwStall;
  assign StallD    = !reset && w_lwStall;
  assign FlushD    = !reset && PCSrcE;
  assign FlushE    = !reset && w_flushE;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_lwStall) r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (PCSrcE)    r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  assign StallCnt = r_stallCnt;
  assign FlushCnt = r_flushCnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counters run 3 bits wide so wrap is reachable.
module tb_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 3;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic              RegWriteD;
  logic [1:0]        ResultSrcD;
  logic              PCSrcE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0]  StallCnt, FlushCnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  // Drive Decode-stage fields and let the combinational outputs settle.
  task automatic applyStimulus(input int rs1, input int rs2, input int rd,
                               input bit rw, input logic [1:0] src, input bit pc);
    Rs1D = REG_AW'(rs1);
    Rs2D = REG_AW'(rs2);
    RdD = REG_AW'(rd);
    RegWriteD = rw;
    ResultSrcD = src;
    PCSrcE = pc;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cntExp(input int n);
    return PERF ? 32'(n % 8) : 32'd0;
  endfunction

  initial begin
    reset = 1'b1;
    applyStimulus(5, 5, 5, 1, 2'b01, 1);
    checkOutput("rst_fwdA", 32'(ForwardAE), 0);
    checkOutput("rst_fwdB", 32'(ForwardBE), 0);
    checkOutput("rst_stallF", 32'(StallF), 0);
    checkOutput("rst_flushD", 32'(FlushD), 0);
    checkOutput("rst_flushE", 32'(FlushE), 0);
    checkOutput("rst_cnt", 32'({StallCnt, FlushCnt}), 0);
    stepClock();
    reset = 1'b0;

    // add x5 then two consumers of x5
    applyStimulus(1, 2, 5, 1, 2'b00, 0);
    checkOutput("empty_fwdA", 32'(ForwardAE), 0);
    stepClock();
    applyStimulus(5, 0, 6, 1, 2'b00, 0);
    checkOutput("alu_noStall", 32'(FlushE), 0);
    stepClock();
    applyStimulus(5, 9, 8, 1, 2'b00, 0);
    checkOutput("memFwdA", 32'(ForwardAE), 32'b10);
    checkOutput("memFwdA_B", 32'(ForwardBE), 0);
    stepClock();
    applyStimulus(0, 0, 7, 1, 2'b00, 0);
    checkOutput("wbFwdA", 32'(ForwardAE), 32'b01);
    checkOutput("wbFwdA_B", 32'(ForwardBE), 0);
    stepClock();
    applyStimulus(0, 0, 7, 1, 2'b00, 0);
    checkOutput("x0src_fwdA", 32'(ForwardAE), 0);
    stepClock();
    applyStimulus(0, 7, 10, 1, 2'b00, 0);
    stepClock();
    // rdM = rdW = 7, rs2E = 7
    applyStimulus(0, 0, 0, 1, 2'b00, 0);
    checkOutput("memPrioB", 32'(ForwardBE), 32'b10);
    checkOutput("memPrio_A", 32'(ForwardAE), 0);
    stepClock();
    applyStimulus(0, 0, 0, 1, 2'b00, 0);
    stepClock();
    // rdM = 0 with regwrite, rs1E = rs2E = 0
    applyStimulus(1, 0, 3, 1, 2'b01, 0);
    checkOutput("x0_fwdA", 32'(ForwardAE), 0);
    checkOutput("x0_fwdB", 32'(ForwardBE), 0);
    stepClock();

    // load x3 in E, dependent Rs2D = 3
    applyStimulus(4, 3, 12, 1, 2'b00, 0);
    checkOutput("lu_stallF", 32'(StallF), 1);
    checkOutput("lu_stallD", 32'(StallD), 1);
    checkOutput("lu_flushE", 32'(FlushE), 1);
    checkOutput("lu_flushD", 32'(FlushD), 0);
    checkOutput("lu_cntBefore", 32'(StallCnt), 0);
    stepClock();
    checkOutput("lu_stallGone", 32'(StallF), 0);
    checkOutput("lu_bubbleB", 32'(ForwardBE), 0);
    checkOutput("lu_cntAfter", 32'(StallCnt), cntExp(1));
    stepClock();
    applyStimulus(1, 0, 3, 1, 2'b01, 0);
    checkOutput("lu_wbFwdB", 32'(ForwardBE), 32'b01);
    checkOutput("lu_wbFwdA", 32'(ForwardAE), 0);
    stepClock();

    // load-use and taken branch together
    applyStimulus(3, 0, 13, 1, 2'b00, 1);
    checkOutput("br_flushD", 32'(FlushD), 1);
    checkOutput("br_flushE", 32'(FlushE), 1);
    checkOutput("br_stallF", 32'(StallF), 1);
    checkOutput("br_flushCntBefore", 32'(FlushCnt), 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 2'b00, 0);
    checkOutput("br_stallGone", 32'(StallF), 0);
    checkOutput("br_flushCnt", 32'(FlushCnt), cntExp(1));
    checkOutput("br_stallCnt", 32'(StallCnt), cntExp(2));
    stepClock();

    // six more load-use stalls drive the 3-bit stall counter through its wrap
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 3, 1, 2'b01, 0);
      stepClock();
      applyStimulus(0, 3, 14, 1, 2'b00, 0);
      checkOutput("wrap_stall", 32'(StallF), 1);
      stepClock();
    end
    checkOutput("wrap_allOnes", 32'(StallCnt), cntExp(7));
    applyStimulus(1, 0, 3, 1, 2'b01, 0);
    stepClock();
    applyStimulus(0, 3, 14, 1, 2'b00, 0);
    stepClock();
    checkOutput("wrap_zero", 32'(StallCnt), cntExp(8));
    checkOutput("wrap_flushCnt", 32'(FlushCnt), cntExp(1));

    // mid-stream reset with add x5 sitting in M
    applyStimulus(1, 2, 5, 1, 2'b00, 0);
    stepClock();
    applyStimulus(5, 0, 6, 1, 2'b00, 0);
    stepClock();
    applyStimulus(5, 0, 6, 1, 2'b00, 1);
    checkOutput("pre_rst_fwdA", 32'(ForwardAE), 32'b10);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_fwdA", 32'(ForwardAE), 0);
    checkOutput("mid_rst_flushD", 32'(FlushD), 0);
    checkOutput("mid_rst_flushE", 32'(FlushE), 0);
    checkOutput("mid_rst_cnt", 32'({StallCnt, FlushCnt}), 0);
    stepClock();
    reset = 1'b0;
    applyStimulus(5, 0, 6, 1, 2'b00, 0);
    stepClock();
    checkOutput("post_rst_fwdA", 32'(ForwardAE), 0);
    checkOutput("post_rst_stall", 32'(StallF), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
